cnn16_window_fetch: RTL and testbench
=====================================

Name: cnn16_window_fetch

Overview:
- Upstream read-master for the 16-bit CNN feature RAM (single-port, 4096 x 16, registered read).
- Scans one stored feature map and gathers each 3x3 convolution window, one pixel read per cycle.
- Presents each window with a valid/ready handshake to the downstream MAC stage.
- Drives the RAM's mem_write/address pins directly; never writes.

Parameters:
DATA_WIDTH, 16, pixel width; must match the RAM
ADDR_WIDTH, 12, RAM address width
DIM_WIDTH, 7, width of the image width/height fields (max 127)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begin scan (ignored unless IDLE)
base_addr  in  ADDR_WIDTH  address of pixel (0,0); row-major map
img_w  in  DIM_WIDTH  map width in pixels
img_h  in  DIM_WIDTH  map height in pixels
mem_write  out  1  RAM write enable; constant 0
address  out  ADDR_WIDTH  RAM read address
mem_rdata  in  DATA_WIDTH  RAM data_out
win_valid  out  1  window_data holds a complete window
win_ready  in  1  consumer accepts the window
win_data  out  9*DATA_WIDTH  element k=3*dy+dx at bits [16k+15:16k]
out_row  out  DIM_WIDTH  output row of current window
out_col  out  DIM_WIDTH  output column of current window
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at end of scan
err  out  1  sticky until next start; bad dimensions

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all outputs 0 (address=0, win_data=0, out_row/out_col=0). Reset mid-scan aborts immediately; the partial window is discarded and no done pulse is issued.
- Output grid: rows 0..img_h-3, cols 0..img_w-3, raster order (col fastest).
- Pixel address = base_addr + (r+dy)*img_w + (c+dx), truncated mod 2^ADDR_WIDTH (wraps; no error).
- RAM latency: address driven in cycle N, mem_rdata valid in N+1; capture into element k in cycle N+1.
- States:
  - IDLE: wait for start.
  - CHECK: one cycle. If img_w<3 or img_h<3, set err, pulse done, return to IDLE. Else go to FETCH with row=col=0.
  - FETCH: 9 cycles issuing k=0..8.
  - DRAIN: 1 cycle capturing k=8.
  - EMIT: win_valid=1; win_data, out_row and out_col stay stable until win_ready. The handshake completes on the cycle win_valid & win_ready. Then advance col; at the last col, col=0 and row++. After the last window, go to DONE; otherwise go to FETCH.
  - DONE: pulse done for 1 cycle, busy=0, go to IDLE.
- Throughput: 11 cycles per window with win_ready held high (9 FETCH, 1 DRAIN, 1 EMIT).
- address holds its last value outside FETCH. mem_write=0 always.
- start while busy: ignored. start in the same cycle as DONE: ignored.
- win_ready while win_valid=0: no effect.

Optional Feature:
- Macro CNN16_WINDOW_PAD_EN.
- When defined: "same" zero-padding.
  - Output grid becomes rows 0..img_h-1, cols 0..img_w-1.
  - Window centre is (r,c); element k maps to (r+dy-1, c+dx-1).
  - Out-of-bounds elements are captured as 0. No RAM address is issued for them; the slot still takes one cycle, so timing is unchanged.
  - err triggers only for img_w=0 or img_h=0.
- When not defined: behaviour as above, with no padding logic.

Decomposition:
- Shared package cnn16_pkg: DATA_WIDTH=16, ADDR_WIDTH=12, KERNEL=3, KTAPS=9, the state enum, and the element-index macro for win_data slicing. The RAM and MAC stage use the same package.
- One sub-module, cnn16_addr_gen: combinational base + row*img_w + col with mod-2^12 wrap, plus the padding in-bounds flag when enabled.

Test Plan:
1. 4x4 map at base 0x100 holding values 0..15, win_ready=1 -> 4 windows. Window (0,0) = {0,1,2,4,5,6,8,9,10}; window (1,1) = {5,6,7,9,10,11,13,14,15}; done 44 cycles after the first FETCH; mem_write never 1.
2. 3x3 map, win_ready held 0 for 20 cycles then 1 -> win_valid stays high with win_data unchanged; exactly one window accepted; then done.
3. base_addr=0xFFE, img_w=img_h=3 -> addresses 0xFFE,0xFFF,0x000,0x001,... in sequence; no err.
4. img_w=2, img_h=5 -> err=1, done pulses within 2 cycles of start, win_valid never asserted.
5. rst_n=0 during FETCH of window 2 -> next cycle all outputs 0 and state IDLE. A new start then rescans from window (0,0).
6. With CNN16_WINDOW_PAD_EN, 3x3 map of values 1..9 -> 9 windows. Window (0,0) = {0,0,0,0,1,2,0,4,5}; no address is issued for padded slots.

Source files
------------

// File: rtl/cnn16_pkg.sv
// Shared constants, FSM states and win_data element slicing for the CNN16 feature-RAM datapath.
// Used by the window fetcher, the feature RAM and the MAC stage.
package cnn16_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 12;
  localparam int KERNEL     = 3;
  localparam int KTAPS      = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FETCH,
    ST_DRAIN,
    ST_EMIT,
    ST_DONE
  } cnn16_state_t;
endpackage

`ifndef CNN16_ELEM
`define CNN16_ELEM(k) (k)*DATA_WIDTH +: DATA_WIDTH
`endif

// File: rtl/cnn16_addr_gen.sv
// Combinational pixel address: base + row*img_w + col, wrapping modulo 2^ADDR_WIDTH.
// With CNN16_WINDOW_PAD_EN the tap is centred on (row,col) and in_bounds flags padded taps.
module cnn16_addr_gen #(
  parameter int ADDR_WIDTH = cnn16_pkg::ADDR_WIDTH,
  parameter int DIM_WIDTH  = 7
) (
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [DIM_WIDTH-1:0]  img_w,
`ifdef CNN16_WINDOW_PAD_EN
  input  logic [DIM_WIDTH-1:0]  img_h,
`endif
  input  logic [DIM_WIDTH-1:0]  row,
  input  logic [DIM_WIDTH-1:0]  col,
  input  logic [1:0]            dy,
  input  logic [1:0]            dx,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  in_bounds
);
  localparam int SW = 2*DIM_WIDTH + 6;

  logic [SW-1:0] pr, pc;

  always_comb begin
    pr = SW'(row) + SW'(dy);
    pc = SW'(col) + SW'(dx);
`ifdef CNN16_WINDOW_PAD_EN
    // A negative coordinate wraps to a huge value; the MSB marks it out of bounds
    pr = pr - SW'(1);
    pc = pc - SW'(1);
    in_bounds = !pr[SW-1] && !pc[SW-1] && (pr < SW'(img_h)) && (pc < SW'(img_w));
`else
    in_bounds = 1'b1;
`endif
    addr = base + ADDR_WIDTH'(pr * SW'(img_w) + pc);
  end
endmodule

// File: rtl/cnn16_window_fetch.sv
// Scans a feature map in the CNN16 RAM and emits 3x3 windows; 11 cycles/window, RAM read latency 1.
// Holds win_data stable under win_ready backpressure; CNN16_WINDOW_PAD_EN enables "same" zero-padding.
module cnn16_window_fetch
  import cnn16_pkg::*;
#(
  parameter int DATA_WIDTH = cnn16_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cnn16_pkg::ADDR_WIDTH,
  parameter int DIM_WIDTH  = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [DIM_WIDTH-1:0]        img_w,
  input  logic [DIM_WIDTH-1:0]        img_h,
  output logic                        mem_write,
  output logic [ADDR_WIDTH-1:0]       address,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic [KTAPS*DATA_WIDTH-1:0] win_data,
  output logic [DIM_WIDTH-1:0]        out_row,
  output logic [DIM_WIDTH-1:0]        out_col,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);
`ifdef CNN16_WINDOW_PAD_EN
  localparam logic [DIM_WIDTH-1:0] MIN_DIM = DIM_WIDTH'(1);
`else
  localparam logic [DIM_WIDTH-1:0] MIN_DIM = DIM_WIDTH'(KERNEL);
`endif
  localparam logic [1:0] KLAST = 2'(KERNEL - 1);

  cnn16_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]       base_q, addr_q, gen_addr;
  logic [DIM_WIDTH-1:0]        w_q, h_q, row_q, col_q;
  logic [1:0]                  dy_q, dx_q;
  logic [3:0]                  cap_k;
  logic                        cap_vld, cap_zero, err_q, in_bounds;
  logic [KTAPS*DATA_WIDTH-1:0] win_q;
  logic                        last_tap, last_win, bad_dim;

  cnn16_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DIM_WIDTH (DIM_WIDTH)
  ) u_addr_gen (
    .base     (base_q),
    .img_w    (w_q),
`ifdef CNN16_WINDOW_PAD_EN
    .img_h    (h_q),
`endif
    .row      (row_q),
    .col      (col_q),
    .dy       (dy_q),
    .dx       (dx_q),
    .addr     (gen_addr),
    .in_bounds(in_bounds)
  );

  assign last_tap = (dy_q == KLAST) && (dx_q == KLAST);
  assign last_win = (col_q == w_q - MIN_DIM) && (row_q == h_q - MIN_DIM);
  assign bad_dim  = (w_q < MIN_DIM) || (h_q < MIN_DIM);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    win_valid = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_CHECK;
      ST_CHECK: begin
        busy      = 1'b1;
        state_nxt = bad_dim ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: begin
        busy = 1'b1;
        if (last_tap) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        busy      = 1'b1;
        win_valid = 1'b1;
        if (win_ready) state_nxt = last_win ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Padded taps issue no read: the bus simply keeps its previous address
  assign address = (state == ST_FETCH && in_bounds) ? gen_addr : addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q   <= '0;
      addr_q   <= '0;
      w_q      <= '0;
      h_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      dy_q     <= '0;
      dx_q     <= '0;
      cap_k    <= '0;
      cap_vld  <= 1'b0;
      cap_zero <= 1'b0;
      err_q    <= 1'b0;
      win_q    <= '0;
    end else begin
      addr_q  <= address;
      cap_vld <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          base_q <= base_addr;
          w_q    <= img_w;
          h_q    <= img_h;
          err_q  <= 1'b0;
        end
        ST_CHECK: begin
          row_q <= '0;
          col_q <= '0;
          dy_q  <= '0;
          dx_q  <= '0;
          if (bad_dim) err_q <= 1'b1;
        end
        ST_FETCH: begin
          cap_vld  <= 1'b1;
          cap_k    <= 4'(dy_q) * 4'd3 + 4'(dx_q);
          cap_zero <= !in_bounds;
          if (dx_q == KLAST) begin
            dx_q <= '0;
            dy_q <= (dy_q == KLAST) ? 2'd0 : dy_q + 2'd1;
          end else begin
            dx_q <= dx_q + 2'd1;
          end
        end
        ST_EMIT: if (win_ready && !last_win) begin
          if (col_q == w_q - MIN_DIM) begin
            col_q <= '0;
            row_q <= row_q + DIM_WIDTH'(1);
          end else begin
            col_q <= col_q + DIM_WIDTH'(1);
          end
        end
        default: ;
      endcase
      // RAM data for the tap addressed last cycle lands now
      if (cap_vld) begin
        for (int i = 0; i < KTAPS; i++) begin
          if (cap_k == 4'(i)) win_q[`CNN16_ELEM(i)] <= cap_zero ? '0 : mem_rdata;
        end
      end
    end
  end

  assign mem_write = 1'b0;
  assign win_data  = win_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign err       = err_q;
endmodule

// File: tb/tb_cnn16_window_fetch.sv
// Randomized self-checking bench for cnn16_window_fetch against a pixel-level window model.
module tb_cnn16_window_fetch;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int DMW = 7;
  localparam int KT = 9;
`ifdef CNN16_WINDOW_PAD_EN
  localparam int MARGIN = 0;
  localparam int CTR = 1;
  localparam int MIN_DIM = 1;
`else
  localparam int MARGIN = 2;
  localparam int CTR = 0;
  localparam int MIN_DIM = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [DMW-1:0] img_w = '0;
  logic [DMW-1:0] img_h = '0;
  logic mem_write;
  logic [AW-1:0] address;
  logic [DW-1:0] mem_rdata = '0;
  logic win_valid;
  logic win_ready = 1'b0;
  logic [KT*DW-1:0] win_data;
  logic [DMW-1:0] out_row, out_col;
  logic busy, done, err;

  logic [DW-1:0] mem [0:4095];

  typedef struct packed {
    logic [DMW-1:0] row;
    logic [DMW-1:0] col;
    logic [KT*DW-1:0] data;
  } win_t;

  win_t obs_win[$];
  win_t exp_win[$];
  logic [AW-1:0] obs_addr[$];
  logic [AW-1:0] exp_addr[$];
  int obs_done_cyc, obs_done_cnt, obs_memw, obs_unstable, obs_vcnt, obs_timeout;
  logic obs_err;
  int total = 0;
  int bad = 0;

  cnn16_window_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .img_w(img_w), .img_h(img_h), .mem_write(mem_write), .address(address),
    .mem_rdata(mem_rdata), .win_valid(win_valid), .win_ready(win_ready),
    .win_data(win_data), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_rdata <= mem[address];

  // Reference: enumerate output pixels and their 3x3 neighbourhoods directly
  task automatic build_model(input logic [AW-1:0] b, input int w, input int h, input logic [AW-1:0] a0);
    int pr, pc, lin;
    logic [AW-1:0] a;
    win_t wv;
    exp_win.delete();
    exp_addr.delete();
    exp_addr.push_back(a0);
    for (int r = 0; r < h - MARGIN; r++) begin
      for (int c = 0; c < w - MARGIN; c++) begin
        wv.row = DMW'(r);
        wv.col = DMW'(c);
        wv.data = '0;
        for (int k = 0; k < KT; k++) begin
          pr = r + k / 3 - CTR;
          pc = c + k % 3 - CTR;
          if (pr >= 0 && pr < h && pc >= 0 && pc < w) begin
            lin = int'(b) + pr * w + pc;
            a = lin[AW-1:0];
            if (a != exp_addr[$]) exp_addr.push_back(a);
            wv.data[k*DW +: DW] = mem[a];
          end
        end
        exp_win.push_back(wv);
      end
    end
  endtask

  // Drives one scan and records what the DUT did; checking is left to the caller
  task automatic run_scan(input int maxc, input int mode, input int stall0, input bit poke);
    int cyc;
    bit dseen, pv, pa;
    win_t cur, prev;
    obs_win.delete();
    obs_addr.delete();
    obs_addr.push_back(address);
    obs_done_cyc = -1; obs_done_cnt = 0; obs_memw = 0; obs_unstable = 0;
    obs_vcnt = 0; obs_timeout = 0; obs_err = 1'b0;
    pv = 1'b0; pa = 1'b0; prev = '0; dseen = 1'b0;
    win_ready = (mode == 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!dseen && cyc < maxc) begin
      if (mem_write) obs_memw++;
      if (address != obs_addr[$]) obs_addr.push_back(address);
      cur = {out_row, out_col, win_data};
      if (win_valid && pv && !pa && cur != prev) obs_unstable++;
      if (done) begin
        obs_done_cnt++;
        obs_done_cyc = cyc;
        obs_err = err;
        dseen = 1'b1;
      end
      if (win_valid) obs_vcnt++;
      case (mode)
        0: win_ready = 1'b1;
        1: win_ready = 1'($urandom_range(0, 1));
        default: win_ready = win_valid && (obs_vcnt > stall0);
      endcase
      if (win_valid && win_ready) obs_win.push_back(cur);
      prev = cur; pv = win_valid; pa = win_ready;
      start = poke && busy && ($urandom_range(0, 3) == 0);
      if (!dseen) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    win_ready = 1'b0;
    if (!dseen) obs_timeout = 1;
    @(posedge clk); #1;
    if (done) obs_done_cnt++;
  endtask

  task automatic test_reset();
    total++;
    if ({address, win_data, out_row, out_col} !== '0) begin
      bad++;
      $display("FAIL reset_data: addr=%h row=%0d col=%0d data=%h want all 0", address, out_row, out_col, win_data);
    end
    total++;
    if ({win_valid, busy, done, err, mem_write} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: valid/busy/done/err/wr=%b want 00000", {win_valid, busy, done, err, mem_write});
    end
  endtask

  task automatic test_map4x4();
    logic [KT*DW-1:0] w00, w11;
    w00 = {16'd10, 16'd9, 16'd8, 16'd6, 16'd5, 16'd4, 16'd2, 16'd1, 16'd0};
    w11 = {16'd15, 16'd14, 16'd13, 16'd11, 16'd10, 16'd9, 16'd7, 16'd6, 16'd5};
    for (int i = 0; i < 16; i++) mem[12'h100 + i] = DW'(i);
    base_addr = 12'h100; img_w = 4; img_h = 4;
    build_model(12'h100, 4, 4, address);
    run_scan(600, 0, 0, 0);
    total++;
    if (obs_done_cnt != 1 || obs_timeout != 0) begin
      bad++; $display("FAIL map4_done: pulses=%0d timeout=%0d want 1/0", obs_done_cnt, obs_timeout);
    end
    total++;
    if (obs_win.size() != exp_win.size()) begin
      bad++; $display("FAIL map4_count: got %0d windows want %0d", obs_win.size(), exp_win.size());
    end
    for (int i = 0; i < obs_win.size() && i < exp_win.size(); i++) begin
      total++;
      if (obs_win[i] !== exp_win[i]) begin
        bad++; $display("FAIL map4_win%0d: got %h want %h", i, obs_win[i], exp_win[i]);
      end
    end
`ifndef CNN16_WINDOW_PAD_EN
    total++;
    if (obs_win.size() != 4 || obs_win[0].data !== w00 || obs_win[3].data !== w11) begin
      bad++; $display("FAIL map4_known: n=%0d w00=%h w11=%h want %h %h", obs_win.size(),
                      obs_win.size() > 0 ? obs_win[0].data : '0, obs_win.size() > 3 ? obs_win[3].data : '0, w00, w11);
    end
`endif
    total++;
    if (obs_done_cyc != 2 + 11 * exp_win.size()) begin
      bad++; $display("FAIL map4_latency: done at %0d want %0d", obs_done_cyc, 2 + 11 * exp_win.size());
    end
    total++;
    if (obs_memw != 0 || obs_err !== 1'b0) begin
      bad++; $display("FAIL map4_wr_err: writes=%0d err=%b want 0/0", obs_memw, obs_err);
    end
    total++;
    if (obs_addr != exp_addr) begin
      bad++; $display("FAIL map4_addr: got %0d addresses want %0d (last %h vs %h)", obs_addr.size(), exp_addr.size(), obs_addr[$], exp_addr[$]);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 9; i++) mem[12'h040 + i] = DW'($urandom);
    base_addr = 12'h040; img_w = 3; img_h = 3;
    build_model(12'h040, 3, 3, address);
    run_scan(800, 2, 20, 0);
    total++;
    if (obs_unstable != 0) begin
      bad++; $display("FAIL bp_stable: %0d changes while stalled want 0", obs_unstable);
    end
    total++;
    if (obs_vcnt != 20 + exp_win.size() || obs_win.size() != exp_win.size()) begin
      bad++; $display("FAIL bp_valid: valid cycles=%0d accepted=%0d want %0d/%0d", obs_vcnt, obs_win.size(), 20 + exp_win.size(), exp_win.size());
    end
    total++;
    if (obs_win.size() < 1 || obs_win[0] !== exp_win[0]) begin
      bad++; $display("FAIL bp_win0: got %h want %h", obs_win.size() > 0 ? obs_win[0] : '0, exp_win[0]);
    end
    total++;
    if (obs_done_cnt != 1 || obs_done_cyc != 22 + 11 * exp_win.size()) begin
      bad++; $display("FAIL bp_done: pulses=%0d at %0d want 1 at %0d", obs_done_cnt, obs_done_cyc, 22 + 11 * exp_win.size());
    end
  endtask

  task automatic test_addr_wrap();
    base_addr = 12'hFFE; img_w = 3; img_h = 3;
    build_model(12'hFFE, 3, 3, address);
    run_scan(400, 0, 0, 0);
    total++;
    if (obs_addr != exp_addr) begin
      bad++; $display("FAIL wrap_trace: got %0d addresses want %0d", obs_addr.size(), exp_addr.size());
    end
    total++;
    if (obs_addr.size() < 4 || obs_addr[1] !== 12'hFFE || obs_addr[2] !== 12'hFFF) begin
      bad++; $display("FAIL wrap_first: got %h %h want ffe fff", obs_addr.size() > 1 ? obs_addr[1] : '0, obs_addr.size() > 2 ? obs_addr[2] : '0);
    end
`ifndef CNN16_WINDOW_PAD_EN
    total++;
    if (obs_addr.size() < 4 || obs_addr[3] !== 12'h000) begin
      bad++; $display("FAIL wrap_zero: got %h want 000", obs_addr.size() > 3 ? obs_addr[3] : '1);
    end
`endif
    total++;
    if (obs_err !== 1'b0 || obs_done_cnt != 1 || obs_win.size() != exp_win.size()) begin
      bad++; $display("FAIL wrap_status: err=%b done=%0d wins=%0d want 0/1/%0d", obs_err, obs_done_cnt, obs_win.size(), exp_win.size());
    end
  endtask

  task automatic test_bad_dim();
    base_addr = 12'h010; img_w = DMW'(MIN_DIM - 1); img_h = 5;
    run_scan(50, 1, 0, 0);
    total++;
    if (obs_err !== 1'b1) begin
      bad++; $display("FAIL bad_err: err=%b want 1", obs_err);
    end
    total++;
    if (obs_done_cnt != 1 || obs_done_cyc < 1 || obs_done_cyc > 2) begin
      bad++; $display("FAIL bad_done: pulses=%0d at %0d want 1 within 2", obs_done_cnt, obs_done_cyc);
    end
    total++;
    if (obs_vcnt != 0) begin
      bad++; $display("FAIL bad_valid: valid cycles=%0d want 0", obs_vcnt);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL bad_sticky: err=%b want 1", err);
    end
  endtask

  task automatic test_reset_midscan();
    bit dseen;
    base_addr = 12'h100; img_w = 4; img_h = 4;
    win_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dseen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) dseen = 1'b1;
    end
    total++;
    if (busy !== 1'b1 || dseen) begin
      bad++; $display("FAIL rst_pre: busy=%b done_seen=%b want 1/0", busy, dseen);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({address, win_data, out_row, out_col, win_valid, busy, done, err, mem_write} !== '0) begin
      bad++; $display("FAIL rst_mid: addr=%h data=%h row=%0d col=%0d ctl=%b want all 0",
                      address, win_data, out_row, out_col, {win_valid, busy, done, err});
    end
    rst_n = 1'b1;
    win_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_idle: done=%b busy=%b want 0/0", done, busy);
    end
    build_model(12'h100, 4, 4, address);
    run_scan(1500, 1, 0, 1);
    total++;
    if (obs_win != exp_win || obs_done_cnt != 1) begin
      bad++; $display("FAIL rst_rescan: wins=%0d first=%h done=%0d want %0d %h 1", obs_win.size(),
                      obs_win.size() > 0 ? obs_win[0] : '0, obs_done_cnt, exp_win.size(), exp_win[0]);
    end
  endtask

`ifdef CNN16_WINDOW_PAD_EN
  task automatic test_pad();
    logic [KT*DW-1:0] w00;
    w00 = {16'd5, 16'd4, 16'd0, 16'd2, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
    for (int i = 0; i < 9; i++) mem[12'h200 + i] = DW'(i + 1);
    base_addr = 12'h200; img_w = 3; img_h = 3;
    build_model(12'h200, 3, 3, address);
    run_scan(600, 0, 0, 0);
    total++;
    if (obs_win.size() != 9 || obs_win[0].data !== w00) begin
      bad++; $display("FAIL pad_w00: n=%0d got %h want 9 %h", obs_win.size(), obs_win.size() > 0 ? obs_win[0].data : '0, w00);
    end
    total++;
    if (obs_win != exp_win) begin
      bad++; $display("FAIL pad_wins: got %0d windows want %0d", obs_win.size(), exp_win.size());
    end
    total++;
    if (obs_addr != exp_addr || obs_done_cyc != 2 + 11 * 9) begin
      bad++; $display("FAIL pad_addr: %0d addresses done at %0d want %0d at %0d", obs_addr.size(), obs_done_cyc, exp_addr.size(), 2 + 11 * 9);
    end
  endtask
`endif

  task automatic test_random();
    int w, h;
    logic [AW-1:0] b;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
      w = MIN_DIM + $urandom_range(0, 5);
      h = MIN_DIM + $urandom_range(0, 5);
      b = AW'($urandom_range(0, 4095));
      base_addr = b; img_w = DMW'(w); img_h = DMW'(h);
      build_model(b, w, h, address);
      run_scan(4000, 1, 0, 1);
      total++;
      if (obs_done_cnt != 1 || obs_timeout != 0 || obs_err !== 1'b0) begin
        bad++; $display("FAIL rnd%0d_done: pulses=%0d timeout=%0d err=%b want 1/0/0", it, obs_done_cnt, obs_timeout, obs_err);
      end
      total++;
      if (obs_win.size() != exp_win.size()) begin
        bad++; $display("FAIL rnd%0d_count: got %0d want %0d (w=%0d h=%0d)", it, obs_win.size(), exp_win.size(), w, h);
      end
      for (int i = 0; i < obs_win.size() && i < exp_win.size(); i++) begin
        total++;
        if (obs_win[i] !== exp_win[i]) begin
          bad++; $display("FAIL rnd%0d_win%0d: got %h want %h", it, i, obs_win[i], exp_win[i]);
        end
      end
      total++;
      if (obs_addr != exp_addr || obs_unstable != 0 || obs_memw != 0) begin
        bad++; $display("FAIL rnd%0d_bus: addrs=%0d/%0d unstable=%0d writes=%0d want equal/0/0", it,
                        obs_addr.size(), exp_addr.size(), obs_unstable, obs_memw);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_map4x4();
    test_backpressure();
    test_addr_wrap();
    test_bad_dim();
    test_reset_midscan();
`ifdef CNN16_WINDOW_PAD_EN
    test_pad();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
